pwr_seq_ctrl: RTL and testbench
===============================

Name: pwr_seq_ctrl

Overview:
- Parametrised regulator power sequencer for the PTC rails (3V3, 2V5, the 12V bricks and future channels).
- Replaces the direct register-bit regulator enables with timed, ordered power-up and reverse-order power-down.
- Adds per-channel alert monitoring with debounce, emergency shutdown and a latched fault.
- Driven from the R/W register block; its status feeds the RO register block.

Parameters:
N_CH, 8, number of regulator channels (1..32)
CNT_W, 24, width of the step-delay counter
DEB_CYC, 16, consecutive cycles an alert must be asserted before it trips (1..255)

Ports:
clk_axi  in  1  system clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
seq_on  in  1  level request: 1 = sequence up / stay on, 0 = sequence down
ch_mask  in  N_CH  channels taking part in the sequence
step_dly  in  CNT_W  clk_axi cycles between consecutive channel steps
alert_n  in  N_CH  asynchronous active-low open-drain regulator alerts
fault_clear  in  1  single-cycle pulse that clears latched faults
ch_en  out  N_CH  registered regulator enables
fault_lat  out  N_CH  latched per-channel fault flags
state  out  3  OFF=0, UP=1, ON=2, DOWN=3, FAULT=4
busy  out  1  high in UP or DOWN

Behaviour:
- Reset (asynchronous, takes effect immediately): ch_en=0, fault_lat=0, state=OFF, busy=0, all counters and indices 0, synchronisers cleared.
- alert_n synchronisation: each bit goes through 2 flops, then an inverter, giving an alert signal.
- Per-channel debounce counter:
  - increments while the synchronised alert is high and ch_en[i]=1;
  - clears otherwise;
  - saturates at DEB_CYC.
- Step delay: step_dly is latched at the start of each UP or DOWN pass. A value of 0 is treated as 1.
- OFF:
  - ch_en=0.
  - If seq_on=1 and fault_lat==0: latch ch_mask into mask_q, load step_dly, set idx=0, go to UP.
- UP:
  - With the wait counter at 0, process channel idx:
    - if mask_q[idx]=1: set ch_en[idx]=1 and load wait = delay-1;
    - if mask_q[idx]=0: skip with no wait, one cycle per channel.
  - Increment idx. Once channel N_CH-1 has been processed and its wait has expired, go to ON.
  - Example: seq_on seen at edge 0 gives state=UP at edge 1 and ch_en[0]=1 at edge 2.
- ON:
  - Hold ch_en.
  - If seq_on=0: set idx=N_CH-1, go to DOWN.
- DOWN:
  - Process channels in descending idx order with the same wait rule.
  - Only channels with ch_en[idx]=1 are cleared and consume a delay; others are skipped in 1 cycle.
  - After idx 0 is done and its wait has expired, go to OFF.
- seq_on dropping during UP:
  - Enter DOWN at the next edge, starting from the highest enabled index.
  - The pending wait is abandoned.
- seq_on rising during DOWN is ignored. DOWN completes, then OFF re-evaluates the request, so the block sequences back up.
- Trip and FAULT:
  - Trip: a debounce counter reaches DEB_CYC in any state. On that same edge:
    - fault_lat[i] is set for every tripping channel (simultaneous trips are all latched);
    - all ch_en drop to 0;
    - state goes to FAULT.
  - A trip takes priority over every other transition.
  - FAULT: ch_en stays 0 and fault_lat holds.
  - fault_clear=1 with seq_on=0: fault_lat=0, go to OFF.
  - fault_clear=1 with seq_on=1: ignored.
  - New alerts in FAULT cannot trip, because ch_en=0.
- ch_mask changes mid-sequence have no effect until the next OFF->UP transition.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
1. N_CH=4, mask=4'b1111, step_dly=3, seq_on rises at edge 0 -> ch_en[0] at edge 2, [1] at 5, [2] at 8, [3] at 11, state=ON at 14; then seq_on=0 -> ch_en[3], [2], [1], [0] drop 3 cycles apart, state=OFF.
2. mask=4'b0101, step_dly=5 -> ch_en[0] at edge 2, ch_en[2] at edge 8 (skipped channel costs 1 cycle), ch_en[1] and ch_en[3] never assert; step_dly=0 -> behaves as 1.
3. DEB_CYC=16, with the block in ON: alert_n[2] low for 15 cycles then high -> no trip; low for 16+ cycles -> fault_lat=4'b0100, ch_en=0, state=FAULT on the same edge.
4. alert_n[1] and alert_n[3] tripping on the same cycle -> fault_lat=4'b1010; fault_clear with seq_on=1 -> no change; seq_on=0 then fault_clear -> fault_lat=0, state=OFF.
5. seq_on dropped while ch_en=4'b0011 in UP -> DOWN clears ch_en[1] first, then [0] step_dly later; ch_en[2] never asserts.
6. rst asserted mid-UP, asynchronously between edges -> ch_en=0, state=OFF immediately; after release with seq_on held high, the sequence restarts from channel 0.

Source files
------------

// File: rtl/pwr_seq_ctrl_if.sv
// Control/status bundle between the register blocks and the regulator power sequencer.
// The master side drives the requests and alerts; the slave side is the sequencer itself.
interface pwr_seq_ctrl_if #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 24
);
  logic             seq_on;
  logic [N_CH-1:0]  ch_mask;
  logic [CNT_W-1:0] step_dly;
  logic [N_CH-1:0]  alert_n;
  logic             fault_clear;
  logic [N_CH-1:0]  ch_en;
  logic [N_CH-1:0]  fault_lat;
  logic [2:0]       state;
  logic             busy;

  modport master (
    output seq_on, ch_mask, step_dly, alert_n, fault_clear,
    input  ch_en, fault_lat, state, busy
  );

  modport slave (
    input  seq_on, ch_mask, step_dly, alert_n, fault_clear,
    output ch_en, fault_lat, state, busy
  );
endinterface

// File: rtl/pwr_seq_ctrl.sv
// Regulator power sequencer: timed ordered power-up, reverse-order power-down,
// and per-channel debounced alert monitoring with emergency shutdown and a latched fault.
module pwr_seq_ctrl #(
  parameter int N_CH    = 8,
  parameter int CNT_W   = 24,
  parameter int DEB_CYC = 16
) (
  input  logic           clk_axi,
  input  logic           rst,
  pwr_seq_ctrl_if.slave  bus
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYC);

  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_UP    = 3'd1;
  localparam logic [2:0] ST_ON    = 3'd2;
  localparam logic [2:0] ST_DOWN  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  logic [N_CH-1:0]  alert_s1_q, alert_s2_q;
  logic [N_CH-1:0]  alert;
  logic [N_CH-1:0]  trip;

  logic [2:0]       state_q, state_d;
  logic [N_CH-1:0]  ch_en_q, ch_en_d;
  logic [N_CH-1:0]  fault_lat_q, fault_lat_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] step_eff;
  logic [IDX_W-1:0] hi_idx;

  // Synchroniser flops reset to "no alert" so nothing can trip while they refill.
  always_ff @(posedge clk_axi or posedge rst) begin
    if (rst) begin
      alert_s1_q <= '1;
      alert_s2_q <= '1;
    end else begin
      alert_s1_q <= bus.alert_n;
      alert_s2_q <= alert_s1_q;
    end
  end

  assign alert = ~alert_s2_q;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_deb
      logic [DEB_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = '0;
        if (alert[gi] && ch_en_q[gi]) begin
          cnt_d = (cnt_q == DEB_MAX) ? DEB_MAX : cnt_q + DEB_W'(1);
        end
      end

      always_ff @(posedge clk_axi or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      // Trip on the edge where the count reaches the threshold.
      assign trip[gi] = (cnt_d == DEB_MAX);
    end
  endgenerate

  assign step_eff = (bus.step_dly == '0) ? CNT_W'(1) : bus.step_dly;

  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_en_q[i]) hi_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_en_d     = ch_en_q;
    fault_lat_d = fault_lat_q;
    mask_d      = mask_q;
    dly_d       = dly_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    last_d      = last_q;

    case (state_q)
      ST_OFF: begin
        ch_en_d = '0;
        if (bus.seq_on && (fault_lat_q == '0)) begin
          mask_d  = bus.ch_mask;
          dly_d   = step_eff;
          idx_d   = '0;
          wait_d  = '0;
          last_d  = 1'b0;
          state_d = ST_UP;
        end
      end
      ST_UP: begin
        if (!bus.seq_on) begin
          state_d = ST_DOWN;
          idx_d   = hi_idx;
          dly_d   = step_eff;
          wait_d  = '0;
          last_d  = 1'b0;
        end else if (wait_q != '0) begin
          wait_d = wait_q - CNT_W'(1);
        end else if (last_q) begin
          state_d = ST_ON;
        end else begin
          if (mask_q[idx_q]) begin
            ch_en_d[idx_q] = 1'b1;
            wait_d         = dly_q - CNT_W'(1);
          end
          last_d = (idx_q == LAST_IDX);
          if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_ON: begin
        if (!bus.seq_on) begin
          state_d = ST_DOWN;
          idx_d   = LAST_IDX;
          dly_d   = step_eff;
          wait_d  = '0;
          last_d  = 1'b0;
        end
      end
      ST_DOWN: begin
        if (wait_q != '0) begin
          wait_d = wait_q - CNT_W'(1);
        end else if (last_q) begin
          state_d = ST_OFF;
        end else begin
          if (ch_en_q[idx_q]) begin
            ch_en_d[idx_q] = 1'b0;
            wait_d         = dly_q - CNT_W'(1);
          end
          last_d = (idx_q == '0);
          if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
        end
      end
      ST_FAULT: begin
        ch_en_d = '0;
        if (bus.fault_clear && !bus.seq_on) begin
          fault_lat_d = '0;
          state_d     = ST_OFF;
        end
      end
      default: begin
        ch_en_d = '0;
        state_d = ST_OFF;
      end
    endcase

    // Emergency shutdown overrides whatever the sequencer was doing this cycle.
    if (trip != '0) begin
      fault_lat_d = fault_lat_q | trip;
      ch_en_d     = '0;
      state_d     = ST_FAULT;
    end

    busy_d = (state_d == ST_UP) || (state_d == ST_DOWN);
  end

  always_ff @(posedge clk_axi or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OFF;
      ch_en_q     <= '0;
      fault_lat_q <= '0;
      mask_q      <= '0;
      dly_q       <= '0;
      wait_q      <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_en_q     <= ch_en_d;
      fault_lat_q <= fault_lat_d;
      mask_q      <= mask_d;
      dly_q       <= dly_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ch_en     = ch_en_q;
  assign bus.fault_lat = fault_lat_q;
  assign bus.state     = state_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl with 4 channels: sequencing timing, skips,
// debounce threshold, fault latch/clear, abort during power-up and async reset.
module tb_pwr_seq_ctrl;
  localparam int N_CH    = 4;
  localparam int CNT_W   = 8;
  localparam int DEB_CYC = 16;

  localparam logic [2:0] OFF   = 3'd0;
  localparam logic [2:0] UP    = 3'd1;
  localparam logic [2:0] ON    = 3'd2;
  localparam logic [2:0] DOWN  = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   e = 0;

  pwr_seq_ctrl_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  pwr_seq_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W), .DEB_CYC(DEB_CYC)) dut (
    .clk_axi (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after rising edge number 'target' (counted from the last e=0).
  task automatic adv(input int target);
    while (e < target) begin
      @(negedge clk);
      e++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.seq_on = 1'b0;
    bus.ch_mask = '0;
    bus.step_dly = '0;
    bus.alert_n = '1;
    bus.fault_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(bus.state), 32'(OFF));
    check("rst_ch_en", 32'(bus.ch_en), 32'h0);
    check("rst_fault", 32'(bus.fault_lat), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Full mask, 3-cycle steps, up then down
    bus.ch_mask = 4'hF; bus.step_dly = 8'd3; bus.seq_on = 1'b1; e = 0;
    adv(1);  check("t1_up_state", 32'(bus.state), 32'(UP));
             check("t1_up_busy", 32'(bus.busy), 32'h1);
             check("t1_e1_ch_en", 32'(bus.ch_en), 32'h0);
    adv(2);  check("t1_e2_ch_en", 32'(bus.ch_en), 32'h1);
    adv(4);  check("t1_e4_ch_en", 32'(bus.ch_en), 32'h1);
    adv(5);  check("t1_e5_ch_en", 32'(bus.ch_en), 32'h3);
    adv(8);  check("t1_e8_ch_en", 32'(bus.ch_en), 32'h7);
    adv(11); check("t1_e11_ch_en", 32'(bus.ch_en), 32'hF);
    adv(13); check("t1_e13_state", 32'(bus.state), 32'(UP));
    adv(14); check("t1_e14_state", 32'(bus.state), 32'(ON));
             check("t1_e14_busy", 32'(bus.busy), 32'h0);
    bus.seq_on = 1'b0; e = 0;
    adv(1);  check("t1_dn_state", 32'(bus.state), 32'(DOWN));
             check("t1_dn_e1_ch_en", 32'(bus.ch_en), 32'hF);
    adv(2);  check("t1_dn_e2_ch_en", 32'(bus.ch_en), 32'h7);
    adv(5);  check("t1_dn_e5_ch_en", 32'(bus.ch_en), 32'h3);
    adv(8);  check("t1_dn_e8_ch_en", 32'(bus.ch_en), 32'h1);
    adv(11); check("t1_dn_e11_ch_en", 32'(bus.ch_en), 32'h0);
    adv(13); check("t1_dn_e13_state", 32'(bus.state), 32'(DOWN));
    adv(14); check("t1_dn_e14_state", 32'(bus.state), 32'(OFF));

    // Sparse mask with 5-cycle steps, then down with step_dly=0
    bus.ch_mask = 4'b0101; bus.step_dly = 8'd5; bus.seq_on = 1'b1; e = 0;
    adv(1);  check("t2_up_state", 32'(bus.state), 32'(UP));
    adv(2);  check("t2_e2_ch_en", 32'(bus.ch_en), 32'h1);
    adv(7);  check("t2_e7_ch_en", 32'(bus.ch_en), 32'h1);
    adv(8);  check("t2_e8_ch_en", 32'(bus.ch_en), 32'h5);
    adv(13); check("t2_e13_state", 32'(bus.state), 32'(UP));
    adv(14); check("t2_e14_state", 32'(bus.state), 32'(ON));
             check("t2_e14_ch_en", 32'(bus.ch_en), 32'h5);
    bus.step_dly = 8'd0; bus.seq_on = 1'b0; e = 0;
    adv(1);  check("t2_dn_state", 32'(bus.state), 32'(DOWN));
    adv(2);  check("t2_dn_e2_ch_en", 32'(bus.ch_en), 32'h5);
    adv(3);  check("t2_dn_e3_ch_en", 32'(bus.ch_en), 32'h1);
    adv(4);  check("t2_dn_e4_ch_en", 32'(bus.ch_en), 32'h1);
    adv(5);  check("t2_dn_e5_ch_en", 32'(bus.ch_en), 32'h0);
             check("t2_dn_e5_state", 32'(bus.state), 32'(DOWN));
    adv(6);  check("t2_dn_e6_state", 32'(bus.state), 32'(OFF));

    // Debounce threshold on channel 2
    bus.ch_mask = 4'hF; bus.step_dly = 8'd1; bus.seq_on = 1'b1; e = 0;
    adv(6);  check("t3_on_state", 32'(bus.state), 32'(ON));
             check("t3_on_ch_en", 32'(bus.ch_en), 32'hF);
    bus.alert_n = 4'b1011; e = 0;
    adv(15); bus.alert_n = 4'hF;
    adv(20); check("t3_15cyc_state", 32'(bus.state), 32'(ON));
             check("t3_15cyc_fault", 32'(bus.fault_lat), 32'h0);
    bus.alert_n = 4'b1011; e = 0;
    adv(17); check("t3_e17_state", 32'(bus.state), 32'(ON));
             check("t3_e17_ch_en", 32'(bus.ch_en), 32'hF);
    adv(18); check("t3_trip_state", 32'(bus.state), 32'(FAULT));
             check("t3_trip_fault", 32'(bus.fault_lat), 32'h4);
             check("t3_trip_ch_en", 32'(bus.ch_en), 32'h0);
             check("t3_trip_busy", 32'(bus.busy), 32'h0);
    bus.alert_n = 4'hF; bus.seq_on = 1'b0; bus.fault_clear = 1'b1; e = 0;
    adv(1);  bus.fault_clear = 1'b0;
             check("t3_clr_state", 32'(bus.state), 32'(OFF));
             check("t3_clr_fault", 32'(bus.fault_lat), 32'h0);

    // Simultaneous trips on channels 1 and 3, clear gating by seq_on
    bus.seq_on = 1'b1; e = 0;
    adv(6);  check("t4_on_state", 32'(bus.state), 32'(ON));
    bus.alert_n = 4'b0101; e = 0;
    adv(18); check("t4_trip_fault", 32'(bus.fault_lat), 32'hA);
             check("t4_trip_state", 32'(bus.state), 32'(FAULT));
             check("t4_trip_ch_en", 32'(bus.ch_en), 32'h0);
    bus.alert_n = 4'hF; bus.fault_clear = 1'b1; e = 0;
    adv(1);  bus.fault_clear = 1'b0;
             check("t4_clr_on_fault", 32'(bus.fault_lat), 32'hA);
             check("t4_clr_on_state", 32'(bus.state), 32'(FAULT));
    adv(3);  bus.seq_on = 1'b0;
    adv(4);  bus.fault_clear = 1'b1;
    adv(5);  bus.fault_clear = 1'b0;
             check("t4_clr_fault", 32'(bus.fault_lat), 32'h0);
             check("t4_clr_state", 32'(bus.state), 32'(OFF));

    // seq_on dropped mid power-up
    bus.ch_mask = 4'hF; bus.step_dly = 8'd4; bus.seq_on = 1'b1; e = 0;
    adv(6);  check("t5_e6_ch_en", 32'(bus.ch_en), 32'h3);
             check("t5_e6_state", 32'(bus.state), 32'(UP));
    bus.seq_on = 1'b0;
    adv(7);  check("t5_e7_state", 32'(bus.state), 32'(DOWN));
             check("t5_e7_ch_en", 32'(bus.ch_en), 32'h3);
    adv(8);  check("t5_e8_ch_en", 32'(bus.ch_en), 32'h1);
    adv(11); check("t5_e11_ch_en", 32'(bus.ch_en), 32'h1);
    adv(12); check("t5_e12_ch_en", 32'(bus.ch_en), 32'h0);
    adv(15); check("t5_e15_state", 32'(bus.state), 32'(DOWN));
    adv(16); check("t5_e16_state", 32'(bus.state), 32'(OFF));

    // Asynchronous reset mid power-up, then restart from channel 0
    bus.step_dly = 8'd3; bus.seq_on = 1'b1; e = 0;
    adv(5);  check("t6_e5_ch_en", 32'(bus.ch_en), 32'h3);
    #2 rst = 1'b1;
    #1 check("t6_async_ch_en", 32'(bus.ch_en), 32'h0);
       check("t6_async_state", 32'(bus.state), 32'(OFF));
       check("t6_async_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst = 1'b0; e = 0;
    adv(1);  check("t6_re_e1_state", 32'(bus.state), 32'(UP));
             check("t6_re_e1_ch_en", 32'(bus.ch_en), 32'h0);
    adv(2);  check("t6_re_e2_ch_en", 32'(bus.ch_en), 32'h1);
    adv(5);  check("t6_re_e5_ch_en", 32'(bus.ch_en), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
